axi_riscv_rsv_table: RTL
========================

# axi_riscv_rsv_table

Parametrised multi-entry LR/SC reservation table, the next-generation reservation tracker behind the AXI RISC-V LR/SC adapter. It holds up to NUM_RSV concurrent reservations keyed by AXI ID, with one reservation per ID. It resolves SC checks with a registered one-cycle response. It invalidates reservations on snooped write bursts, and optionally on a per-entry timeout. It sits between the adapter's AR/AW decode logic and its R/B response muxing.

## Interface
- ADDR_BEGIN, 0, first byte address of the exclusive range (closed interval)
- ADDR_END, 0, last byte address of the exclusive range
- AXI_ADDR_WIDTH, 64, address width
- AXI_ID_WIDTH, 4, ID width
- NUM_RSV, 4, number of reservation entries (≥1)
- GRAN_LOG2, 3, log2 of the reservation granule in bytes
- RSV_TIMEOUT, 1024, entry lifetime in cycles (used only with the timeout feature)
- Clock and reset: one clock; reset is synchronous and active-high.
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- lr_valid_i / lr_ready_o  in/out  1  LR registration handshake
- lr_id_i  in  AXI_ID_WIDTH  LR issuer ID
- lr_addr_i  in  AXI_ADDR_WIDTH  LR address
- sc_valid_i / sc_ready_o  in/out  1  SC check request handshake
- sc_id_i  in  AXI_ID_WIDTH  SC issuer ID
- sc_addr_i  in  AXI_ADDR_WIDTH  SC address
- sc_resp_valid_o / sc_resp_ready_i  out/in  1  SC result handshake
- sc_resp_ok_o  out  1  1 = SC may proceed (EXOKAY), 0 = fail
- sc_resp_id_o  out  AXI_ID_WIDTH  ID of the resolved SC
- wr_valid_i  in  1  write-snoop strobe, single cycle, no backpressure
- wr_addr_i  in  AXI_ADDR_WIDTH  write start address
- wr_len_i  in  8  AXI len
- wr_size_i  in  3  AXI size
- occupancy_o  out  $clog2(NUM_RSV+1)  number of valid entries

## Operation
- Entry contents: valid, id, granule (addr >> GRAN_LOG2).
- Address range check: an address is in range when ADDR_BEGIN ≤ addr ≤ ADDR_END.
- LR (handshake, in range):
  - If a valid entry has the same id, overwrite its granule.
  - Otherwise allocate the lowest-index free entry.
  - If no entry is free, evict the entry at victim_ptr, then victim_ptr = (victim_ptr+1) mod NUM_RSV.
- LR out of range: accepted; no table change.
- SC (handshake):
  - Result is ok=1 only if it is in range and a valid entry matches both id and granule.
  - The entry holding sc_id_i (if any) is cleared regardless of the result.
  - Result and ID are registered into the response slot.
- Write snoop: clears every valid entry whose granule lies in [wr_addr_i>>G, (wr_addr_i + ((wr_len_i+1)<<wr_size_i) − 1)>>G].
  - Computed at AXI_ADDR_WIDTH+1 bits; on overflow the end saturates to all-ones.
  - WRAP bursts are presented as the equivalent aligned INCR span by the caller.
- Same-cycle ordering: snoop, then SC, then LR.
  - An SC whose matching entry is hit by a same-cycle snoop fails.
  - An LR whose address is covered by a same-cycle snoop still installs its entry.
- lr_ready_o = !rst_i && !sc_valid_i (SC has priority; LR and SC never both handshake in one cycle).
- sc_ready_o = !rst_i && (!sc_resp_valid_o || sc_resp_ready_i).

## Timing
- Reset values:
  - all entries invalid; victim_ptr=0; occupancy_o=0
  - sc_resp_valid_o=0, sc_resp_ok_o=0, sc_resp_id_o=0
  - lr_ready_o=0, sc_ready_o=0 while rst_i=1
- Reset mid-operation: a pending SC response is dropped; timeout counters are cleared.
- SC latency: request handshake in cycle N gives sc_resp_valid_o=1 in N+1. The response holds until sc_resp_ready_i=1.
- Back-to-back SCs: one per cycle when sc_resp_ready_i is held at 1.
- LR visibility: an LR handshaked in N is visible to an SC handshaked in N+1. occupancy_o updates in N+1.
- Snoop effect: wr_valid_i in N affects an SC handshaked in N and every later SC.

## Configuration
- AXI_RSV_TIMEOUT_EN defined:
  - Each entry has a $clog2(RSV_TIMEOUT+1)-bit age counter, zeroed on install or overwrite and incremented every cycle while the entry is valid.
  - The entry is invalidated in the cycle its age reaches RSV_TIMEOUT.
  - An SC handshaked in that same cycle fails.
- AXI_RSV_TIMEOUT_EN undefined: no counters; entries live until SC, snoop, eviction, or reset.

## Test plan
- LR id=1 addr=0x1000, then SC id=1 addr=0x1004 (same 8B granule) -> next cycle resp_valid=1, ok=1, id=1; occupancy 1→0.
- NUM_RSV=4: LRs from ids 0..4 to distinct granules -> entry for id 0 evicted; SC id=0 gives ok=0, SC id=4 gives ok=1.
- LR id=2 addr=0x2000; write snoop addr=0x1FF8, len=3, size=3 (span 0x1FF8–0x2017) -> SC id=2 gives ok=0.
- Same cycle: SC id=3 (valid reservation) and a snoop covering it -> ok=0. LR asserted with SC -> lr_ready_o=0.
- sc_resp_ready_i=0 for 3 cycles -> response held stable and sc_ready_o=0; mid-stream rst_i -> all outputs at reset values the next cycle.
- With AXI_RSV_TIMEOUT_EN, RSV_TIMEOUT=16: LR, then SC 15 cycles later -> ok=1; repeat with SC 16 cycles later -> ok=0.

Source files
------------

// File: rtl/axi_riscv_rsv_table.sv
// Multi-entry LR/SC reservation table keyed by AXI ID, with write-snoop invalidation.
// Optional per-entry lifetime limit enabled by defining AXI_RSV_TIMEOUT_EN.
module axi_riscv_rsv_table #(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 4,
  parameter logic [AXI_ADDR_WIDTH-1:0] ADDR_BEGIN = '0,
  parameter logic [AXI_ADDR_WIDTH-1:0] ADDR_END   = '0,
  parameter int unsigned NUM_RSV        = 4,
  parameter int unsigned GRAN_LOG2      = 3,
  parameter int unsigned RSV_TIMEOUT    = 1024
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          lr_valid_i,
  output logic                          lr_ready_o,
  input  logic [AXI_ID_WIDTH-1:0]       lr_id_i,
  input  logic [AXI_ADDR_WIDTH-1:0]     lr_addr_i,
  input  logic                          sc_valid_i,
  output logic                          sc_ready_o,
  input  logic [AXI_ID_WIDTH-1:0]       sc_id_i,
  input  logic [AXI_ADDR_WIDTH-1:0]     sc_addr_i,
  output logic                          sc_resp_valid_o,
  input  logic                          sc_resp_ready_i,
  output logic                          sc_resp_ok_o,
  output logic [AXI_ID_WIDTH-1:0]       sc_resp_id_o,
  input  logic                          wr_valid_i,
  input  logic [AXI_ADDR_WIDTH-1:0]     wr_addr_i,
  input  logic [7:0]                    wr_len_i,
  input  logic [2:0]                    wr_size_i,
  output logic [$clog2(NUM_RSV+1)-1:0]  occupancy_o
);

  localparam int unsigned GW = AXI_ADDR_WIDTH - GRAN_LOG2;
  localparam int unsigned VW = (NUM_RSV > 1) ? $clog2(NUM_RSV) : 1;
  localparam int unsigned OW = $clog2(NUM_RSV + 1);
  localparam logic [AXI_ADDR_WIDTH:0] ONE = 1;

  logic [NUM_RSV-1:0]      valid_q, valid_d;
  logic [AXI_ID_WIDTH-1:0] id_q   [NUM_RSV];
  logic [AXI_ID_WIDTH-1:0] id_d   [NUM_RSV];
  logic [GW-1:0]           gran_q [NUM_RSV];
  logic [GW-1:0]           gran_d [NUM_RSV];
  logic [VW-1:0]           victim_q, victim_d;

`ifdef AXI_RSV_TIMEOUT_EN
  localparam int unsigned AGW = $clog2(RSV_TIMEOUT + 1);
  logic [AGW-1:0]          age_q  [NUM_RSV];
  logic [AGW-1:0]          age_d  [NUM_RSV];
  logic [NUM_RSV-1:0]      expire;
`endif

  logic                    resp_valid_q, resp_ok_q, resp_ok_d;
  logic [AXI_ID_WIDTH-1:0] resp_id_q;

  logic                    sc_fire, lr_fire;
  logic                    sc_in_range, lr_in_range;
  logic [GW-1:0]           sc_gran, lr_gran, snoop_lo, snoop_hi;
  logic [AXI_ADDR_WIDTH:0] snoop_bytes, snoop_end_full;
  logic [AXI_ADDR_WIDTH-1:0] snoop_end;
  logic                    lr_hit, free_found;
  logic [VW-1:0]           lr_hit_idx, free_idx, tgt_idx;
  logic [OW-1:0]           occ;

  // Borrow-based compare avoids constant-compare issues when ADDR_BEGIN is zero.
  function automatic logic in_range(input logic [AXI_ADDR_WIDTH-1:0] addr);
    logic [AXI_ADDR_WIDTH:0] lo_diff, hi_diff;
    lo_diff = {1'b0, addr} - {1'b0, ADDR_BEGIN};
    hi_diff = {1'b0, ADDR_END} - {1'b0, addr};
    return !lo_diff[AXI_ADDR_WIDTH] && !hi_diff[AXI_ADDR_WIDTH];
  endfunction

  assign lr_ready_o = !rst_i && !sc_valid_i;
  assign sc_ready_o = !rst_i && (!resp_valid_q || sc_resp_ready_i);
  assign sc_fire    = sc_valid_i && sc_ready_o;
  assign lr_fire    = lr_valid_i && lr_ready_o;

  assign sc_in_range = in_range(sc_addr_i);
  assign lr_in_range = in_range(lr_addr_i);
  assign sc_gran     = sc_addr_i[AXI_ADDR_WIDTH-1:GRAN_LOG2];
  assign lr_gran     = lr_addr_i[AXI_ADDR_WIDTH-1:GRAN_LOG2];

  // Burst end computed one bit wider so an address-space wrap saturates.
  assign snoop_bytes    = ({{(AXI_ADDR_WIDTH-7){1'b0}}, wr_len_i} + ONE) << wr_size_i;
  assign snoop_end_full = {1'b0, wr_addr_i} + snoop_bytes - ONE;
  assign snoop_end      = snoop_end_full[AXI_ADDR_WIDTH] ? '1
                                                         : snoop_end_full[AXI_ADDR_WIDTH-1:0];
  assign snoop_lo       = wr_addr_i[AXI_ADDR_WIDTH-1:GRAN_LOG2];
  assign snoop_hi       = snoop_end[AXI_ADDR_WIDTH-1:GRAN_LOG2];

`ifdef AXI_RSV_TIMEOUT_EN
  // Expire in the cycle the age would step to RSV_TIMEOUT.
  always_comb begin
    expire = '0;
    for (int i = 0; i < int'(NUM_RSV); i++) begin
      expire[i] = valid_q[i] && (({1'b0, age_q[i]} + 1'b1) == (AGW+1)'(RSV_TIMEOUT));
    end
  end
`endif

  always_comb begin
    valid_d    = valid_q;
    id_d       = id_q;
    gran_d     = gran_q;
    victim_d   = victim_q;
    resp_ok_d  = 1'b0;
    lr_hit     = 1'b0;
    lr_hit_idx = '0;
    free_found = 1'b0;
    free_idx   = '0;
    tgt_idx    = '0;
`ifdef AXI_RSV_TIMEOUT_EN
    for (int i = 0; i < int'(NUM_RSV); i++) begin
      age_d[i] = valid_q[i] ? age_q[i] + 1'b1 : '0;
      if (expire[i]) valid_d[i] = 1'b0;
    end
`endif
    for (int i = 0; i < int'(NUM_RSV); i++) begin
      if (wr_valid_i && gran_q[i] >= snoop_lo && gran_q[i] <= snoop_hi) valid_d[i] = 1'b0;
    end

    if (sc_fire) begin
      for (int i = 0; i < int'(NUM_RSV); i++) begin
        if (valid_q[i] && id_q[i] == sc_id_i) begin
          if (valid_d[i] && gran_q[i] == sc_gran && sc_in_range) resp_ok_d = 1'b1;
          valid_d[i] = 1'b0;
        end
      end
    end

    if (lr_fire && lr_in_range) begin
      for (int i = 0; i < int'(NUM_RSV); i++) begin
        if (valid_q[i] && id_q[i] == lr_id_i) begin
          lr_hit     = 1'b1;
          lr_hit_idx = VW'(i);
        end
      end
      for (int i = int'(NUM_RSV) - 1; i >= 0; i--) begin
        if (!valid_d[i]) begin
          free_found = 1'b1;
          free_idx   = VW'(i);
        end
      end
      if (lr_hit) begin
        tgt_idx = lr_hit_idx;
      end else if (free_found) begin
        tgt_idx = free_idx;
      end else begin
        tgt_idx  = victim_q;
        victim_d = (victim_q == VW'(NUM_RSV - 1)) ? '0 : victim_q + 1'b1;
      end
      valid_d[tgt_idx] = 1'b1;
      id_d[tgt_idx]    = lr_id_i;
      gran_d[tgt_idx]  = lr_gran;
`ifdef AXI_RSV_TIMEOUT_EN
      age_d[tgt_idx]   = '0;
`endif
    end
  end

  always_comb begin
    occ = '0;
    for (int i = 0; i < int'(NUM_RSV); i++) occ = occ + OW'(valid_q[i]);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q      <= '0;
      victim_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_ok_q    <= 1'b0;
      resp_id_q    <= '0;
      for (int i = 0; i < int'(NUM_RSV); i++) begin
        id_q[i]   <= '0;
        gran_q[i] <= '0;
`ifdef AXI_RSV_TIMEOUT_EN
        age_q[i]  <= '0;
`endif
      end
    end else begin
      valid_q  <= valid_d;
      victim_q <= victim_d;
      for (int i = 0; i < int'(NUM_RSV); i++) begin
        id_q[i]   <= id_d[i];
        gran_q[i] <= gran_d[i];
`ifdef AXI_RSV_TIMEOUT_EN
        age_q[i]  <= age_d[i];
`endif
      end
      if (sc_fire) begin
        resp_valid_q <= 1'b1;
        resp_ok_q    <= resp_ok_d;
        resp_id_q    <= sc_id_i;
      end else if (sc_resp_ready_i) begin
        resp_valid_q <= 1'b0;
      end
    end
  end

  assign sc_resp_valid_o = resp_valid_q;
  assign sc_resp_ok_o    = resp_ok_q;
  assign sc_resp_id_o    = resp_id_q;
  assign occupancy_o     = occ;

endmodule
